// File: rtl/axi_aw_allocator_if.sv
// AW channel bundle shared by the requesting ports, the allocator, the downstream slave and the ID FIFO.
interface axi_aw_allocator_if #(
  parameter int N_TARG_PORT  = 7,
  parameter int LOG_N_TARG   = $clog2(N_TARG_PORT),
  parameter int AW_PAYLOAD_W = 72
);
  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0] awpayload_i;
  logic [N_TARG_PORT-1:0]                   awvalid_i;
  logic [N_TARG_PORT-1:0]                   awready_o;
  logic [AW_PAYLOAD_W-1:0]                  awpayload_o;
  logic                                     awvalid_o;
  logic                                     awready_i;
  logic                                     push_ID_o;
  logic [LOG_N_TARG+N_TARG_PORT-1:0]        ID_o;
  logic                                     grant_FIFO_ID_i;

  // The allocator sits on the slave side of this bundle; requesters and the sink drive the master side.
  modport slave (
    input  awpayload_i, awvalid_i, awready_i, grant_FIFO_ID_i,
    output awready_o, awpayload_o, awvalid_o, push_ID_o, ID_o
  );

  modport master (
    output awpayload_i, awvalid_i, awready_i, grant_FIFO_ID_i,
    input  awready_o, awpayload_o, awvalid_o, push_ID_o, ID_o
  );
endinterface

// File: rtl/axi_aw_allocator.sv
// Round-robin AW arbiter feeding a one-entry registered output slice, with a routing-ID push
// to the write-data allocator for every accepted address.
module axi_aw_allocator #(
  parameter int N_TARG_PORT  = 7,
  parameter int LOG_N_TARG   = $clog2(N_TARG_PORT),
  parameter int AW_PAYLOAD_W = 72
) (
  input logic               clk,
  input logic               rst,
  axi_aw_allocator_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]              state_q;
  logic [LOG_N_TARG-1:0]   rr_q;
  logic [LOG_N_TARG-1:0]   rr_next;
  logic [LOG_N_TARG-1:0]   winner;
  logic [LOG_N_TARG-1:0]   high_winner;
  logic [LOG_N_TARG-1:0]   wrap_winner;
  logic                    high_found;
  logic                    any_valid;
  logic                    accept;
  logic [N_TARG_PORT-1:0]  winner_oh;
  logic [AW_PAYLOAD_W-1:0] payload_q;

  // Rotating priority: the lowest requester at or above rr_q wins; otherwise wrap to the lowest overall.
  always_comb begin
    high_winner = '0;
    wrap_winner = '0;
    high_found  = 1'b0;
    for (int p = N_TARG_PORT - 1; p >= 0; p--) begin
      if (bus.awvalid_i[p]) begin
        wrap_winner = LOG_N_TARG'(p);
        if (p >= int'(rr_q)) begin
          high_winner = LOG_N_TARG'(p);
          high_found  = 1'b1;
        end
      end
    end
    winner = high_found ? high_winner : wrap_winner;
  end

  assign any_valid = |bus.awvalid_i;
  assign accept    = any_valid & bus.grant_FIFO_ID_i & ((state_q == EMPTY) | bus.awready_i) & ~rst;
  assign winner_oh = {{(N_TARG_PORT-1){1'b0}}, 1'b1} << winner;
  assign rr_next   = (winner == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : winner + LOG_N_TARG'(1);

  assign bus.awready_o   = accept ? winner_oh : '0;
  assign bus.push_ID_o   = accept;
  assign bus.ID_o        = {winner, winner_oh};
  assign bus.awvalid_o   = (state_q == FULL);
  assign bus.awpayload_o = payload_q;

  // A new accept refills the slice even while it drains, sustaining one AW per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      rr_q      <= '0;
      payload_q <= '0;
    end else if (accept) begin
      state_q   <= FULL;
      rr_q      <= rr_next;
      payload_q <= bus.awpayload_i[winner];
    end else if (bus.awready_i) begin
      state_q   <= EMPTY;
    end
  end
endmodule

// File: tb/tb_axi_aw_allocator.sv
// Randomised scoreboard bench for axi_aw_allocator: a spec-level model queues expected
// per-cycle handshakes, routing IDs and slave payloads; a monitor pops and compares them.
module tb_axi_aw_allocator;
  localparam int N   = 7;
  localparam int LW  = 3;
  localparam int PW  = 72;
  localparam int IDW = LW + N;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_aw_allocator_if #(.N_TARG_PORT(N), .LOG_N_TARG(LW), .AW_PAYLOAD_W(PW)) bus ();

  axi_aw_allocator #(.N_TARG_PORT(N), .LOG_N_TARG(LW), .AW_PAYLOAD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [N-1:0] awready;
    logic         push;
    logic         awvalid;
  } cycle_exp_t;

  cycle_exp_t     cycle_q[$];
  logic [IDW-1:0] id_q[$];
  logic [PW-1:0]  aw_q[$];

  int model_rr;
  bit model_full;
  int check_count = 0;
  int pass_count  = 0;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // One cycle of stimulus; the model predicts this cycle's outputs from its state, then advances.
  task automatic apply_stimulus(input bit rst_v, input logic [N-1:0] valid, input bit slave_ready, input bit grant);
    int         winner;
    bit         accept;
    cycle_exp_t e;
    @(posedge clk);
    #1;
    rst                 = rst_v;
    bus.awvalid_i       = valid;
    bus.awready_i       = slave_ready;
    bus.grant_FIFO_ID_i = grant;
    for (int p = 0; p < N; p++) bus.awpayload_i[p] = PW'({$urandom(), $urandom(), $urandom()});
    e = '0;
    if (rst_v) begin
      model_full = 1'b0;
      model_rr   = 0;
      aw_q.delete();
    end else begin
      winner = -1;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (model_rr + k) % N;
        if (winner < 0 && valid[p]) winner = p;
      end
      accept    = (winner >= 0) && grant && (!model_full || slave_ready);
      e.awvalid = model_full;
      e.push    = accept;
      if (accept) begin
        e.awready = N'(1) << winner;
        id_q.push_back({LW'(winner), N'(1) << winner});
        aw_q.push_back(bus.awpayload_i[winner]);
        model_full = 1'b1;
        model_rr   = (winner + 1) % N;
      end else if (slave_ready) begin
        model_full = 1'b0;
      end
    end
    cycle_q.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents at each falling edge against the queued expectations.
  initial begin
    cycle_exp_t e;
    logic [IDW-1:0] exp_id;
    logic [PW-1:0]  exp_pl;
    forever begin
      @(negedge clk);
      if (cycle_q.size() > 0) begin
        e = cycle_q.pop_front();
        check_output("awready_o", 128'(bus.awready_o), 128'(e.awready));
        check_output("push_ID_o", 128'(bus.push_ID_o), 128'(e.push));
        check_output("awvalid_o", 128'(bus.awvalid_o), 128'(e.awvalid));
      end
      if (bus.push_ID_o === 1'b1) begin
        if (id_q.size() == 0) begin
          check_count++;
          $display("[TB] FAIL id_push: got push with ID %0h, expected no push", bus.ID_o);
        end else begin
          exp_id = id_q.pop_front();
          check_output("ID_o", 128'(bus.ID_o), 128'(exp_id));
        end
      end
      if (bus.awvalid_o === 1'b1 && bus.awready_i === 1'b1) begin
        if (aw_q.size() == 0) begin
          check_count++;
          $display("[TB] FAIL slave_handshake: got payload %0h, expected no valid", bus.awpayload_o);
        end else begin
          exp_pl = aw_q.pop_front();
          check_output("awpayload_o", 128'(bus.awpayload_o), 128'(exp_pl));
        end
      end
    end
  end

  initial begin
    rst                 = 1'b1;
    bus.awvalid_i       = '0;
    bus.awready_i       = 1'b0;
    bus.grant_FIFO_ID_i = 1'b0;
    bus.awpayload_i     = '0;
    model_rr            = 0;
    model_full          = 1'b0;

    repeat (2) apply_stimulus(1'b1, '0, 1'b0, 1'b1);

    // Ports 0 and 3 from reset: port 0 first, then alternation while the slave keeps up.
    apply_stimulus(1'b0, 7'b0001001, 1'b0, 1'b1);
    apply_stimulus(1'b0, 7'b0001001, 1'b0, 1'b1);
    repeat (4) apply_stimulus(1'b0, 7'b0001001, 1'b1, 1'b1);

    // Push the pointer to 6, then take port 6 and wrap.
    apply_stimulus(1'b0, 7'b0100000, 1'b1, 1'b1);
    apply_stimulus(1'b0, 7'b1000000, 1'b1, 1'b1);

    // ID FIFO full: slice drains, nothing accepted until grant returns.
    apply_stimulus(1'b0, 7'b0000100, 1'b1, 1'b0);
    apply_stimulus(1'b0, 7'b0000100, 1'b1, 1'b0);
    apply_stimulus(1'b0, 7'b0000100, 1'b0, 1'b1);

    // Slave stalled with requests pending.
    repeat (5) apply_stimulus(1'b0, 7'b1111011, 1'b0, 1'b1);
    apply_stimulus(1'b0, 7'b1111011, 1'b1, 1'b1);

    // Reset with a full slice, then ports 4 and 5 must start from port 0.
    apply_stimulus(1'b0, 7'b0000001, 1'b0, 1'b1);
    apply_stimulus(1'b1, 7'b0110000, 1'b0, 1'b1);
    apply_stimulus(1'b0, 7'b0110000, 1'b0, 1'b1);

    repeat (400) begin
      apply_stimulus($urandom_range(0, 59) == 0, N'($urandom()),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
    end

    repeat (3) apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    check_output("leftover_payloads", 128'(aw_q.size()), 128'(0));
    check_output("leftover_ids", 128'(id_q.size()), 128'(0));
    check_output("leftover_cycles", 128'(cycle_q.size()), 128'(0));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
